// File: rtl/cache_mem_responder.sv
// Main-memory responder for the cache line interface: fixed-latency line fills and
// write-backs against internal storage, with a sticky flag for initiator protocol errors.
module cache_mem_responder #(
    parameter int LATENCY    = 8,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         mem_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    state_t                  state_r;
    state_t                  state_s;
    logic [7:0]              cnt_r;
    logic                    op_wr_r;
    logic [27:0]             addr_r;
    logic [127:0]            wdata_r;
    logic [127:0]            store_r [DEPTH];
    logic                    accept_s;
    logic                    access_s;
    logic                    err_set_s;
    logic                    req_match_s;
    logic [DEPTH_LOG2-1:0]   idx_s;

    // Next-state decode; a request with both strobes high is latched as a write.
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        access_s    = 1'b0;
        err_set_s   = 1'b0;
        idx_s       = addr_r[DEPTH_LOG2-1:0];
        req_match_s = (mem_read | mem_write) && (mem_write == op_wr_r) && (mem_addr == addr_r);
        case (state_r)
            IDLE: begin
                if (mem_read | mem_write) begin
                    accept_s  = 1'b1;
                    err_set_s = mem_read & mem_write;
                    state_s   = BUSY;
                end else begin
                    state_s   = IDLE;
                end
            end
            BUSY: begin
                if (!req_match_s) begin
                    err_set_s = 1'b1;
                    state_s   = IDLE;
                end else if (cnt_r == 8'd0) begin
                    access_s  = 1'b1;
                    state_s   = READY;
                end else begin
                    state_s   = BUSY;
                end
            end
            READY:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, request latch, latency counter and registered outputs.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_r   <= IDLE;
            cnt_r     <= 8'd0;
            op_wr_r   <= 1'b0;
            addr_r    <= 28'd0;
            wdata_r   <= 128'd0;
            mem_ready <= 1'b0;
            mem_rdata <= 128'd0;
            mem_err   <= 1'b0;
        end else begin
            state_r   <= state_s;
            mem_ready <= (state_s == READY);
            if (err_set_s) begin
                mem_err <= 1'b1;
            end
            if (accept_s) begin
                op_wr_r <= mem_write;
                addr_r  <= mem_addr;
                wdata_r <= mem_wdata;
                cnt_r   <= CNT_INIT;
            end else if ((state_r == BUSY) && (cnt_r != 8'd0)) begin
                cnt_r   <= cnt_r - 8'd1;
            end
            if (access_s && !op_wr_r) begin
                mem_rdata <= store_r[idx_s];
            end
        end
    end

    // Backing storage is deliberately not reset; an aborted write never reaches it.
    always_ff @(posedge clk) begin
        if (access_s && op_wr_r) begin
            store_r[idx_s] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized self-checking bench: transaction-level model of line storage, latency and error flag.
module tb_cache_mem_responder;

    localparam int LAT   = 4;
    localparam int LIMIT = 3 * LAT + 10;

    logic         clk = 1'b0;
    logic         proc_reset;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         mem_err;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [127:0] model_mem [256];
    logic [127:0] last_rdata;
    logic         exp_err;
    int           last_pulse;

    cache_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(8)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drive one request from a negedge and wait for its completion pulse.
    task automatic run_req(input bit rd, input bit wr, input logic [27:0] a,
                           input logic [127:0] d, input bit keep, input int exp_k,
                           input string tag);
        int k;
        bit got;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = d;
        k   = 0;
        got = 1'b0;
        while (k < LIMIT && !got) begin
            @(negedge clk);
            k++;
            if (mem_ready) got = 1'b1;
        end
        check_eq({tag, "_latency"}, 128'(k), 128'(exp_k));
        if (wr) begin
            model_mem[a[7:0]] = d;
            if (rd) exp_err = 1'b1;
        end else begin
            last_rdata = model_mem[a[7:0]];
        end
        check_eq({tag, "_rdata"}, mem_rdata, last_rdata);
        check_eq({tag, "_err"}, 128'(mem_err), 128'(exp_err));
        last_pulse = cyc;
        if (!keep) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    initial begin
        logic [7:0]   pool [7];
        logic [27:0]  a;
        logic [127:0] d;
        logic [127:0] old3;
        int           t1;
        int           nready;

        pool = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h05, 8'h20, 8'h10};
        proc_reset = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = 28'd0;
        mem_wdata  = 128'd0;
        exp_err    = 1'b0;
        last_rdata = 128'd0;
        #1;
        check_eq("reset_ready", 128'(mem_ready), 128'd0);
        check_eq("reset_rdata", mem_rdata, 128'd0);
        check_eq("reset_err", 128'(mem_err), 128'd0);
        @(negedge clk);
        @(negedge clk);
        proc_reset = 1'b0;

        // Directed write/read of line 5 starting around cycle 10.
        while (cyc < 10) @(negedge clk);
        run_req(1'b0, 1'b1, 28'h0000005, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0, LAT + 1, "wr5");
        @(negedge clk);
        run_req(1'b1, 1'b0, 28'h0000005, 128'd0, 1'b0, LAT + 1, "rd5");
        check_eq("rd5_value", mem_rdata, 128'h0123456789ABCDEF0123456789ABCDEF);

        // Give every line used later known contents.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            run_req(1'b0, 1'b1, {20'd0, pool[i]}, rand_line(), 1'b0, LAT + 1, "init");
        end
        old3 = rand_line();
        @(negedge clk);
        run_req(1'b0, 1'b1, 28'h0000003, old3, 1'b0, LAT + 1, "init3");

        // Dirty-line miss: write-back then fill, pulses LAT+2 apart.
        @(negedge clk);
        run_req(1'b0, 1'b1, 28'h0000010, rand_line(), 1'b0, LAT + 1, "wb10");
        t1 = last_pulse;
        @(negedge clk);
        run_req(1'b1, 1'b0, 28'h0000020, 128'd0, 1'b0, LAT + 1, "fill20");
        check_eq("b2b_spacing", 128'(last_pulse - t1), 128'(LAT + 2));

        // Read held across its pulse is re-accepted only in the following idle cycle.
        @(negedge clk);
        run_req(1'b1, 1'b0, 28'h0000022, 128'd0, 1'b1, LAT + 1, "hold1");
        run_req(1'b1, 1'b0, 28'h0000022, 128'd0, 1'b0, LAT + 2, "hold2");

        // Randomized traffic over the initialized lines with aliased upper bits.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a      = 28'($urandom());
            a[7:0] = pool[$urandom_range(0, 6)];
            if ($urandom_range(0, 1) == 0) begin
                run_req(1'b1, 1'b0, a, 128'd0, 1'b0, LAT + 1, "rnd_rd");
            end else begin
                run_req(1'b0, 1'b1, a, rand_line(), 1'b0, LAT + 1, "rnd_wr");
            end
        end

        // Address change mid-BUSY aborts the request and sets the sticky error.
        @(negedge clk);
        mem_read = 1'b1;
        mem_addr = 28'h0000033;
        @(negedge clk);
        @(negedge clk);
        mem_addr = 28'h0000034;
        @(negedge clk);
        mem_read = 1'b0;
        exp_err  = 1'b1;
        nready   = 0;
        for (int i = 0; i < 2 * LAT; i++) begin
            @(negedge clk);
            if (mem_ready) nready++;
        end
        check_eq("abort_no_ready", 128'(nready), 128'd0);
        check_eq("abort_err", 128'(mem_err), 128'd1);
        check_eq("abort_rdata", mem_rdata, last_rdata);
        run_req(1'b1, 1'b0, 28'h0000044, 128'd0, 1'b0, LAT + 1, "after_abort");

        // Reset during a write to line 3 drops the write.
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 28'h0000003;
        mem_wdata = ~old3;
        @(negedge clk);
        @(negedge clk);
        #1 proc_reset = 1'b1;
        #1;
        check_eq("midreset_ready", 128'(mem_ready), 128'd0);
        check_eq("midreset_rdata", mem_rdata, 128'd0);
        check_eq("midreset_err", 128'(mem_err), 128'd0);
        mem_write = 1'b0;
        exp_err    = 1'b0;
        last_rdata = 128'd0;
        @(negedge clk);
        proc_reset = 1'b0;
        @(negedge clk);
        run_req(1'b1, 1'b0, 28'h0000003, 128'd0, 1'b0, LAT + 1, "rd3_after_reset");
        check_eq("rd3_old", mem_rdata, old3);

        // Upper address bits alias onto the same line.
        d = rand_line();
        @(negedge clk);
        run_req(1'b0, 1'b1, 28'h0000101, d, 1'b0, LAT + 1, "alias_wr");
        @(negedge clk);
        run_req(1'b1, 1'b0, 28'h0000001, 128'd0, 1'b0, LAT + 1, "alias_rd");
        check_eq("alias_value", mem_rdata, d);

        // Both strobes high: performed as a write, error flagged.
        d = rand_line();
        @(negedge clk);
        run_req(1'b1, 1'b1, 28'h0000042, d, 1'b0, LAT + 1, "both_hi");
        @(negedge clk);
        run_req(1'b1, 1'b0, 28'h0000042, 128'd0, 1'b0, LAT + 1, "both_hi_rd");
        check_eq("both_hi_value", mem_rdata, d);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
